// File: rtl/event_encoder_if.sv
// event_encoder_if: bundle of the event inputs, the encoded-index output
// handshake and the status outputs of event_encoder.
//
// Handshake: the encoder drives out_valid and a; the consumer drives
// out_ready. A transfer happens on every rising clk edge where out_valid and
// out_ready are both high. While out_valid is high and out_ready is low, a and
// out_valid are held stable. out_valid only falls after a transfer (or on rst).
// out_valid does not depend combinationally on out_ready.
//
// Signals:
//   y          N  event pulses (one cycle high = one event on that line)
//   out_ready  1  consumer accepts the current index
//   out_valid  1  a holds a valid event index
//   a          W  encoded event index
//   pending    N  captured events not yet loaded into the output
//   busy       1  pending non-empty or out_valid
//   overflow   1  sticky lost-event flag
//
// Modports: master = the encoder, slave = the producer/consumer side.
interface event_encoder_if #(
   parameter int N = 8,
   parameter int W = 3
);
   logic [N-1:0] y;
   logic         out_ready;
   logic         out_valid;
   logic [W-1:0] a;
   logic [N-1:0] pending;
   logic         busy;
   logic         overflow;

   modport master (
      input  y, out_ready,
      output out_valid, a, pending, busy, overflow
   );

   modport slave (
      output y, out_ready,
      input  out_valid, a, pending, busy, overflow
   );
endinterface

// File: rtl/event_encoder.sv
// event_encoder: collects one-cycle event pulses on N lines into a pending
// set and emits the index of one pending event per transfer over a
// valid/ready handshake. The selection is either fixed priority (highest
// index wins, RR=0) or round-robin starting after the last loaded index
// (RR=1).
//
// Ports:
//   clk  rising-edge clock
//   rst  asynchronous, active-high reset
//   bus  event_encoder_if master modport (y, out_ready in; out_valid, a,
//        pending, busy, overflow out)
//
// Parameters: N event lines (2..256), W = clog2(N) index width,
//             RR = 0 fixed priority / 1 round-robin.
module event_encoder #(
   parameter int N  = 8,
   parameter int W  = 3,
   parameter int RR = 0
) (
   input  logic            clk,
   input  logic            rst,
   event_encoder_if.master bus
);

   logic [N-1:0] pending_q;
   logic [W-1:0] a_q;
   logic [W-1:0] ptr_q;
   logic         valid_q;
   logic         overflow_q;

   logic [W-1:0] sel;
   logic         slot_free;
   logic         load;
   logic [N-1:0] load_mask;
   logic [N-1:0] lost;

   // Candidate selection works on the registered pending set only, so y never
   // reaches a in the same cycle.
   always_comb begin
      int idx;
      sel = '0;
      idx = 0;
      if (RR == 0) begin
         // Ascending scan: the last hit is the highest set index.
         for (int i = 0; i < N; i++) begin
            if (pending_q[i]) sel = W'(i);
         end
      end else begin
         // Descending over the scan offset so that the last hit is the one
         // closest after ptr. ptr+1+k is at most 2N-1, so one wrap suffices.
         for (int k = N - 1; k >= 0; k--) begin
            idx = int'(ptr_q) + 1 + k;
            if (idx >= N) idx = idx - N;
            if (pending_q[W'(idx)]) sel = W'(idx);
         end
      end
   end

   assign slot_free = !valid_q || bus.out_ready;
   assign load      = slot_free && (|pending_q);

   always_comb begin
      load_mask = '0;
      if (load) load_mask[sel] = 1'b1;
   end

   // An event is lost when it hits a line that is still pending and is not
   // being moved to the output on this edge. The bit simply stays set.
   assign lost = bus.y & pending_q & ~load_mask;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         pending_q  <= '0;
         a_q        <= '0;
         valid_q    <= 1'b0;
         overflow_q <= 1'b0;
         ptr_q      <= W'(N - 1);
      end else begin
         pending_q <= (pending_q & ~load_mask) | bus.y;
         if (|lost) overflow_q <= 1'b1;
         if (load) begin
            a_q     <= sel;
            valid_q <= 1'b1;
            ptr_q   <= sel;
         end else if (valid_q && bus.out_ready) begin
            // Slot drained with nothing to refill it; a keeps its last value.
            valid_q <= 1'b0;
         end
      end
   end

   assign bus.out_valid = valid_q;
   assign bus.a         = a_q;
   assign bus.pending   = pending_q;
   assign bus.busy      = (|pending_q) || valid_q;
   assign bus.overflow  = overflow_q;

endmodule

// File: tb/tb_event_encoder.sv
// Testbench for event_encoder: one fixed-priority and one round-robin
// instance share the same stimulus; a behavioural model of each is checked
// every cycle, and directed sequences pin literal expectations.
module tb_event_encoder;

   localparam int N = 8;
   localparam int W = 3;

   // ---------------- clock / reset ----------------
   logic clk;
   logic rst;
   logic [N-1:0] y;
   logic out_ready;

   initial clk = 1'b0;
   always #5 clk = ~clk;

   event_encoder_if #(.N(N), .W(W)) bus0 ();
   event_encoder_if #(.N(N), .W(W)) bus1 ();

   assign bus0.y         = y;
   assign bus0.out_ready = out_ready;
   assign bus1.y         = y;
   assign bus1.out_ready = out_ready;

   event_encoder #(.N(N), .W(W), .RR(0)) dut_fixed (.clk(clk), .rst(rst), .bus(bus0));
   event_encoder #(.N(N), .W(W), .RR(1)) dut_rr    (.clk(clk), .rst(rst), .bus(bus1));

   int vectors     = 0;
   int miscompares = 0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      vectors++;
      if (act !== exp) begin
         miscompares++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   // ---------------- behavioural model ----------------
   // Index 0 models the fixed-priority instance, index 1 the round-robin one.
   logic [N-1:0] m_pend[2];
   bit           m_valid[2];
   int           m_a[2];
   int           m_ptr[2];
   bit           m_ovf[2];

   always @(posedge clk or posedge rst) begin
      int s, idx;
      bit found, slot_free, do_load;
      if (rst) begin
         for (int m = 0; m < 2; m++) begin
            m_pend[m]  = '0;
            m_valid[m] = 1'b0;
            m_a[m]     = 0;
            m_ptr[m]   = N - 1;
            m_ovf[m]   = 1'b0;
         end
      end else begin
         for (int m = 0; m < 2; m++) begin
            slot_free = !m_valid[m] || out_ready;
            found = 1'b0;
            s = 0;
            if (m == 0) begin
               for (int i = N - 1; i >= 0; i--)
                  if (!found && m_pend[m][i]) begin s = i; found = 1'b1; end
            end else begin
               for (int k = 1; k <= N; k++) begin
                  idx = (m_ptr[m] + k) % N;
                  if (!found && m_pend[m][idx]) begin s = idx; found = 1'b1; end
               end
            end
            do_load = slot_free && found;
            for (int i = 0; i < N; i++)
               if (y[i] && m_pend[m][i] && !(do_load && i == s)) m_ovf[m] = 1'b1;
            if (do_load) begin
               m_pend[m][s] = 1'b0;
               m_a[m]       = s;
               m_valid[m]   = 1'b1;
               m_ptr[m]     = s;
            end else if (m_valid[m] && out_ready) begin
               m_valid[m] = 1'b0;
            end
            m_pend[m] = m_pend[m] | y;
         end
      end
   end

   // ---------------- scoreboard compare, every cycle ----------------
   task automatic cmp_inst(input int m, input logic v, input logic [W-1:0] a,
                           input logic [N-1:0] p, input logic b, input logic o);
      string pfx;
      pfx = (m == 0) ? "fixed" : "rr";
      chk({pfx, " out_valid"}, 32'(v), 32'(m_valid[m]));
      chk({pfx, " a"},         32'(a), 32'(m_a[m]));
      chk({pfx, " pending"},   32'(p), 32'(m_pend[m]));
      chk({pfx, " busy"},      32'(b), 32'((m_pend[m] != '0) || m_valid[m]));
      chk({pfx, " overflow"},  32'(o), 32'(m_ovf[m]));
   endtask

   always @(negedge clk) begin
      cmp_inst(0, bus0.out_valid, bus0.a, bus0.pending, bus0.busy, bus0.overflow);
      cmp_inst(1, bus1.out_valid, bus1.a, bus1.pending, bus1.busy, bus1.overflow);
   end

   // ---------------- driver tasks ----------------
   task automatic tick();
      @(negedge clk);
   endtask

   // Called just after a negedge: asynchronous reset pulse between edges.
   task automatic do_reset();
      #2 rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
   endtask

   // ---------------- directed + random stimulus ----------------
   initial begin
      rst = 1'b1;
      y = '0;
      out_ready = 1'b0;
      tick();
      rst = 1'b0;

      // Reset mid-stream with pending=5A, out_valid=1 and overflow set.
      y = 8'h01; tick();
      y = 8'h5A; tick();
      y = 8'h5A; tick();
      y = 8'h00;
      chk("pre-rst valid",    32'(bus0.out_valid), 32'd1);
      chk("pre-rst pending",  32'(bus0.pending),   32'h5A);
      chk("pre-rst overflow", 32'(bus0.overflow),  32'd1);
      #2 rst = 1'b1;
      #1;
      chk("rst pending",  32'(bus0.pending),   32'h0);
      chk("rst valid",    32'(bus0.out_valid), 32'd0);
      chk("rst a",        32'(bus0.a),         32'd0);
      chk("rst overflow", 32'(bus0.overflow),  32'd0);
      chk("rst busy",     32'(bus0.busy),      32'd0);
      chk("rst rr busy",  32'(bus1.busy),      32'd0);
      tick();
      rst = 1'b0;

      // Single event: 2-cycle latency, one cycle of valid.
      out_ready = 1'b1;
      y = 8'b0000_1000; tick(); y = '0;
      chk("single pend", 32'(bus0.pending),   32'h08);
      chk("single v0",   32'(bus0.out_valid), 32'd0);
      tick();
      chk("single v1",   32'(bus0.out_valid), 32'd1);
      chk("single a",    32'(bus0.a),         32'd3);
      chk("single pend0",32'(bus0.pending),   32'h0);
      tick();
      chk("single v2",   32'(bus0.out_valid), 32'd0);
      chk("single hold", 32'(bus0.a),         32'd3);

      // Fixed priority vs round-robin from reset.
      do_reset();
      y = 8'b1010_0101; tick(); y = '0;
      tick(); chk("fix a0", 32'(bus0.a), 32'd7); chk("rr a0", 32'(bus1.a), 32'd0);
      tick(); chk("fix a1", 32'(bus0.a), 32'd5); chk("rr a1", 32'(bus1.a), 32'd2);
      tick(); chk("fix a2", 32'(bus0.a), 32'd2); chk("rr a2", 32'(bus1.a), 32'd5);
      tick(); chk("fix a3", 32'(bus0.a), 32'd0); chk("rr a3", 32'(bus1.a), 32'd7);
      tick();
      chk("fix done", 32'(bus0.out_valid), 32'd0);
      chk("rr done",  32'(bus1.out_valid), 32'd0);
      chk("fix novf", 32'(bus0.overflow),  32'd0);
      y = 8'b1000_0001; tick(); y = '0;
      tick(); chk("rr wrap a0", 32'(bus1.a), 32'd0); chk("fix 81 a0", 32'(bus0.a), 32'd7);
      tick(); chk("rr wrap a1", 32'(bus1.a), 32'd7); chk("fix 81 a1", 32'(bus0.a), 32'd0);
      tick(); chk("rr wrap done", 32'(bus1.out_valid), 32'd0);

      // Backpressure and overflow.
      do_reset();
      out_ready = 1'b0;
      y = 8'b0001_0000; tick(); y = '0;
      tick();
      chk("bp a",     32'(bus0.a),         32'd4);
      chk("bp valid", 32'(bus0.out_valid), 32'd1);
      y = 8'b0001_0000; tick(); y = '0;
      chk("bp pend",  32'(bus0.pending),   32'h10);
      chk("bp novf",  32'(bus0.overflow),  32'd0);
      chk("bp hold",  32'(bus0.a),         32'd4);
      y = 8'b0001_0000; tick(); y = '0;
      chk("bp ovf",   32'(bus0.overflow),  32'd1);
      out_ready = 1'b1;
      tick();
      chk("bp again v", 32'(bus0.out_valid), 32'd1);
      chk("bp again a", 32'(bus0.a),         32'd4);
      tick();
      chk("bp drained", 32'(bus0.out_valid), 32'd0);
      chk("bp sticky",  32'(bus0.overflow),  32'd1);

      // Arrival on the same edge the bit is loaded.
      do_reset();
      y = 8'b0000_0100; tick();
      y = 8'b0000_0100; tick(); y = '0;
      chk("sim a",    32'(bus0.a),         32'd2);
      chk("sim v",    32'(bus0.out_valid), 32'd1);
      chk("sim pend", 32'(bus0.pending),   32'h04);
      chk("sim novf", 32'(bus0.overflow),  32'd0);
      tick();
      chk("sim a2",   32'(bus0.a),         32'd2);
      chk("sim v2",   32'(bus0.out_valid), 32'd1);
      tick();
      chk("sim end",  32'(bus0.out_valid), 32'd0);
      chk("sim novf2",32'(bus0.overflow),  32'd0);

      // Randomized traffic with varying density, backpressure and resets.
      for (int c = 0; c < 3000; c++) begin
         tick();
         case ((c / 500) % 3)
            0: y = ($urandom_range(0, 3) == 0) ? N'($urandom_range(0, 255)) : '0;
            1: y = N'($urandom_range(0, 255));
            default: y = ($urandom_range(0, 7) == 0) ? (N'(1) << $urandom_range(0, N - 1)) : '0;
         endcase
         out_ready = ((c / 250) % 2 == 0) ? ($urandom_range(0, 3) != 0)
                                          : ($urandom_range(0, 3) == 0);
         if ($urandom_range(0, 299) == 0) begin
            #2 rst = 1'b1;
            #1 rst = 1'b0;
         end
      end
      tick();
      y = '0;
      tick();

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule

// File: doc/event_encoder.md
# event_encoder

Parametrised, registered event encoder: it collects one-cycle event pulses on N request lines into a pending set. It then emits the binary index of one pending event per transfer over a valid/ready output handshake. Events that arrive together are all delivered, one at a time, in fixed-priority or round-robin order. It sits between raw status/interrupt lines and any consumer that needs one encoded event index per cycle.

## Interface
- N, default 8: number of event lines; legal range 2..256.
- W, default 3: index width; must equal clog2(N).
- RR, default 0: 0 = fixed priority (highest index wins); 1 = round-robin.

- clk  in  1  single clock; all state updates on rising edge.
- rst  in  1  asynchronous, active-high reset.
- y  in  N  event pulses; bit i high for a cycle = one event on line i.
- out_ready  in  1  consumer accepts the current output.
- out_valid  out  1  a holds a valid event index.
- a  out  W  encoded event index.
- pending  out  N  registered set of events captured but not yet loaded into the output.
- busy  out  1  |pending or out_valid (combinational from registers).
- overflow  out  1  sticky; set when an event is lost.

## Operation
- Transfer: out_valid & out_ready at a rising edge.
- Load condition at each edge: (out_valid == 0 or transfer) and pending != 0.
- On load: a <= selected index s; out_valid <= 1; bit s is cleared from pending.
- If the slot is freed (transfer) and pending == 0: out_valid <= 0, and a holds its last value.
- Candidate set is the pending register only; y never bypasses straight into a.
- Pending update each edge: pending <= (pending & ~load_mask) | y.
- Fixed mode (RR=0): s = highest set index in pending.
- RR mode (RR=1): s = first set bit scanning upward from (ptr+1) mod N, wrapping past N-1 to 0. ptr <= s on every load.
- Overflow: y[i]=1 while pending[i]=1 and bit i is not being loaded this edge. This sets overflow <= 1, held until rst. The lost event is merged (pending[i] stays 1).
- y[i]=1 on the same edge pending[i] is loaded: pending[i] stays 1 as a new event, with no overflow.
- y[i]=1 while index i sits only in the output register: pending[i] is set normally, with no overflow.
- Reset values: pending=0, a=0, out_valid=0, overflow=0, ptr=N-1, so the first RR search starts at index 0.

## Timing
- Latency with the slot empty: y pulse sampled at edge k, pending bit set after edge k, a/out_valid valid after edge k+1. That is 2 cycles.
- Throughput: one index per cycle while out_ready=1 and pending != 0, with no bubbles between back-to-back loads.
- Backpressure: while out_valid=1 and out_ready=0, a and out_valid stay stable and pending keeps accumulating.
- out_valid never drops without a transfer, except on rst.
- rst asserted at any time clears all state immediately, independent of clk.
- An output pending at reset is discarded, and overflow clears.
- First load after rst deassertion needs the normal 2-cycle latency from a new y pulse.
- busy and pending derive from registers only; there is no combinational path y -> any output.

## Test plan
- Reset: assert rst mid-stream with pending=8'h5A and out_valid=1 -> immediately pending=0, out_valid=0, a=0, overflow=0, busy=0.
- Single event (N=8, RR=0, out_ready=1): y=8'b00001000 for one cycle at edge k -> after edge k+1 out_valid=1, a=3 for exactly one cycle. Pending returns to 0 after edge k+1.
- Fixed priority (RR=0, out_ready=1): y=8'b10100101 for one cycle -> a = 7, 5, 2, 0 on four consecutive cycles, then out_valid=0, with no overflow.
- Round-robin (RR=1, from reset): same y=8'b10100101 -> a = 0, 2, 5, 7. Follow with y=8'b10000001 -> a = 0 then 7 (ptr=7 wraps to 0).
- Backpressure/overflow (RR=0): out_ready=0 and y=8'b00010000 -> a=4, out_valid=1 held. Then:
  - pulse y=8'b00010000 -> pending=8'b00010000, overflow=0.
  - pulse it again -> overflow=1 (sticky).
  - raise out_ready -> a=4 transfers, then a=4 once more, then out_valid=0.
- Simultaneous load and arrival: pending=8'b00000100, slot empty, y=8'b00000100 on the load edge -> a=2 now and a=2 again next cycle, with overflow=0.
